ps2_rx: RTL

- PS/2 device-to-host serial receiver. Deserialises 11-bit keyboard frames (start, 8 data LSB-first, odd parity, stop) into scancode bytes.
- Drives the `keyboard_data` byte bus consumed by the note key detector. It is the producer end of that interface.
- Sits between the board's PS/2 pins and the audio controller's key-decoding logic. Runs entirely in the 50 MHz system clock domain.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_edge_filter.sv | 62 ++++++
 rtl/ps2_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
// Frame: start, 8 data bits LSB first, odd parity, stop.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_SHIFT      = 8'h12;
    localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter: synchronises the PS/2 pins and deglitches the clock.
// Ports: clk, rst (sync, active low), ps2_clk/ps2_data (raw pins),
//        fall (1-cycle strobe on filtered clock 1->0),
//        data_s (synchronised, unfiltered data).
module ps2_edge_filter
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_filt_q;
    logic                   r_fall;
    logic                   w_clk_s;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign data_s  = r_dat_sync[SYNC_STAGES-1];
    assign fall    = r_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_cnt      <= '0;
            r_filt     <= 1'b1;
            r_filt_q   <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_filt_q   <= r_filt;
            // Strobe is registered once more so that the stop-bit edge
            // reaches the outputs SYNC_STAGES + FILTER_LEN + 2 clocks later.
            r_fall     <= r_filt_q & ~r_filt;
            // Any sample agreeing with the current level restarts the run.
            if (w_clk_s != r_filt) begin
                if (r_cnt == CW'(FILTER_LEN - 1)) begin
                    r_filt <= w_clk_s;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver producing scancode bytes.
// Ports: clk (50 MHz), rst (sync, active low), ps2_clk/ps2_data (raw pins),
//        keyboard_data (last accepted byte, held), data_valid (1-cycle
//        pulse on update), frame_err (1-cycle pulse on parity/stop/timeout).
// Option: PS2_RX_BREAK_FILTER_EN turns F0 <code> into a single 8'h00 byte.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       w_fall;
    logic       w_data_s;
    logic       w_to_hit;
    logic       w_accept;

    ps2_state_t r_state;
    ps2_state_t w_state_nx;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nx;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nx;
    logic       r_par;
    logic       w_par_nx;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nx;
    logic [7:0] r_kbd;
    logic [7:0] w_kbd_nx;
    logic       r_valid;
    logic       w_valid_nx;
    logic       r_err;
    logic       w_err_nx;
`ifdef PS2_RX_BREAK_FILTER_EN
    logic       r_brk;
    logic       w_brk_nx;
`endif

    ps2_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (w_fall),
        .data_s   (w_data_s)
    );

    assign keyboard_data = r_kbd;
    assign data_valid    = r_valid;
    assign frame_err     = r_err;

    assign w_to_hit = (r_state != IDLE) &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    // Stop bit high and odd parity over data plus parity bit.
    assign w_accept = w_data_s && (^{r_shift, r_par});

    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_bit_cnt_nx = r_bit_cnt;
        w_par_nx     = r_par;
        w_kbd_nx     = r_kbd;
        w_valid_nx   = 1'b0;
        w_err_nx     = 1'b0;
`ifdef PS2_RX_BREAK_FILTER_EN
        w_brk_nx     = r_brk;
`endif

        if (r_state == IDLE || w_fall || w_to_hit) begin
            w_to_cnt_nx = '0;
        end else begin
            w_to_cnt_nx = r_to_cnt + 1'b1;
        end

        // A fall on the expiry cycle takes priority over the timeout.
        if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_data_s) begin
                        w_state_nx   = DATA;
                        w_bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    w_shift_nx[r_bit_cnt] = w_data_s;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = PARITY;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    w_par_nx   = w_data_s;
                    w_state_nx = STOP;
                end
                STOP: begin
                    w_state_nx = IDLE;
                    if (w_accept) begin
`ifdef PS2_RX_BREAK_FILTER_EN
                        if (r_brk) begin
                            w_brk_nx   = 1'b0;
                            w_kbd_nx   = 8'h00;
                            w_valid_nx = 1'b1;
                        end else if (r_shift == PS2_BREAK) begin
                            w_brk_nx = 1'b1;
                        end else begin
                            w_kbd_nx   = r_shift;
                            w_valid_nx = 1'b1;
                        end
`else
                        w_kbd_nx   = r_shift;
                        w_valid_nx = 1'b1;
`endif
                    end else begin
                        w_err_nx = 1'b1;
`ifdef PS2_RX_BREAK_FILTER_EN
                        w_brk_nx = 1'b0;
`endif
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end else if (w_to_hit) begin
            w_state_nx = IDLE;
            w_err_nx   = 1'b1;
`ifdef PS2_RX_BREAK_FILTER_EN
            w_brk_nx   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
            r_kbd     <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_par     <= w_par_nx;
            r_to_cnt  <= w_to_cnt_nx;
            r_kbd     <= w_kbd_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
        end
    end

`ifdef PS2_RX_BREAK_FILTER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_brk <= 1'b0;
        end else begin
            r_brk <= w_brk_nx;
        end
    end
`endif

endmodule
